// File: rtl/conv5x5_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv5x5_engine_pkg
//  Description : Shared sizes, load-FSM states and the window index helper
//                for the 5x5 convolution datapath and its line buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package conv5x5_engine_pkg;

  localparam int I_F_BW = 8;                          // unsigned pixel width
  localparam int W_BW   = 8;                          // signed weight width
  localparam int KX     = 5;                          // kernel width
  localparam int KY     = 5;                          // kernel height
  localparam int KK     = KX * KY;                    // taps per kernel
  localparam int P_BW   = I_F_BW + W_BW + 1;          // one product
  localparam int RS_BW  = P_BW + $clog2(KX);          // one row sum
  localparam int ACC_BW = P_BW + $clog2(KK);          // final result (22)
  localparam int CNT_BW = $clog2(KK);                 // weight load index

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_BUSY = 1'b1
  } ld_state_e;

  // Linear position of window element (wy, wx) inside the packed window.
  function automatic int win_idx(input int wy, input int wx);
    return wy * KX + wx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv5x5_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv5x5_engine_if
//  Description : Window, weight and result streams of the 5x5 convolution
//                engine. master = producer/consumer side, slave = engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv5x5_engine_if;
  import conv5x5_engine_pkg::*;

  logic                     i_window_valid;
  logic [KK*I_F_BW-1:0]     i_window;
  logic                     i_w_valid;
  logic signed [W_BW-1:0]   i_w_data;
  logic                     o_w_loaded;
  logic                     o_out_valid;
  logic signed [ACC_BW-1:0] o_out_data;

  modport master (
    output i_window_valid, i_window, i_w_valid, i_w_data,
    input  o_w_loaded, o_out_valid, o_out_data
  );

  modport slave (
    input  i_window_valid, i_window, i_w_valid, i_w_data,
    output o_w_loaded, o_out_valid, o_out_data
  );
endinterface
`default_nettype wire

// File: rtl/conv5x5_engine_conv_row_sum.sv
`default_nettype none
// ============================================================================
//  Module      : conv_row_sum
//  Description : One kernel row: KX pixel x weight products registered in
//                the first stage, their sum registered in the second stage.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_row_sum
  import conv5x5_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en1_i,     // a window is accepted this edge
  input  logic                    en2_i,     // stage-1 products are valid
  input  logic [KX*I_F_BW-1:0]    pix_i,
  input  logic [KX*W_BW-1:0]      wgt_i,
  output logic signed [RS_BW-1:0] sum_o
);

  logic signed [P_BW-1:0]  prod_d [KX];
  logic signed [P_BW-1:0]  prod_q [KX];
  logic signed [RS_BW-1:0] sum_d;
  logic signed [RS_BW-1:0] sum_q;

  // Pixels are zero-extended so they stay non-negative in the signed multiply.
  always_comb begin
    for (int c = 0; c < KX; c++) begin
      prod_d[c] = $signed({{(P_BW-I_F_BW){1'b0}}, pix_i[c*I_F_BW +: I_F_BW]})
                * $signed({{(P_BW-W_BW){wgt_i[c*W_BW+W_BW-1]}}, wgt_i[c*W_BW +: W_BW]});
    end
  end

  // Stage 1: capture the products of an accepted window.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < KX; c++) prod_q[c] <= '0;
    end else if (en1_i) begin
      for (int c = 0; c < KX; c++) prod_q[c] <= prod_d[c];
    end
  end

  // Sign-extended sum of the registered products.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < KX; c++) sum_d = sum_d + RS_BW'(prod_q[c]);
  end

  // Stage 2: capture the row sum.
  always_ff @(posedge clk) begin
    if (reset)      sum_q <= '0;
    else if (en2_i) sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/conv5x5_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv5x5_engine
//  Description : Signed 5x5 convolution of a packed pixel window against a
//                double-buffered kernel; fixed 3-cycle latency, 1 window/clk.
//                Optional build macro CONV_RELU_EN clamps negative results.
//  Revision    : 1.0  initial release
// ============================================================================
module conv5x5_engine
  import conv5x5_engine_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  conv5x5_engine_if.slave  bus
);

  localparam logic [CNT_BW-1:0] c_last = CNT_BW'(KK - 1);

  ld_state_e                     state_q, state_d;
  logic [CNT_BW-1:0]             cnt_q, cnt_d;
  logic [KK-1:0][W_BW-1:0]       shadow_q, shadow_d;
  logic [KK-1:0][W_BW-1:0]       active_q;
  logic                          loaded_q;
  logic                          commit;
  logic                          v1_q, v2_q, v3_q;
  logic signed [ACC_BW-1:0]      acc_d, out_q;
  logic signed [RS_BW-1:0]       w_row_sum [KY];
  logic                          w_accept;

  assign w_accept = bus.i_window_valid & loaded_q;

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LD_IDLE;
    else       state_q <= state_d;
  end

  // Load FSM next state: leave IDLE on the first weight, return on the last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE: if (bus.i_w_valid) state_d = LD_BUSY;
      LD_BUSY: if (bus.i_w_valid && cnt_q == c_last) state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  // Load FSM outputs: shadow write, counter update and the commit strobe.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    if (bus.i_w_valid) shadow_d[cnt_q] = bus.i_w_data;
    case (state_q)
      LD_IDLE: if (bus.i_w_valid) cnt_d = CNT_BW'(1);
      LD_BUSY: begin
        if (bus.i_w_valid) begin
          if (cnt_q == c_last) begin
            commit = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_q + CNT_BW'(1);
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Weight banks; the commit copies the shadow including the final weight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      if (commit) begin
        active_q <= shadow_d;
        loaded_q <= 1'b1;
      end
    end
  end

  // Rows read the active bank as it stands before any same-edge commit.
  for (genvar r = 0; r < KY; r++) begin : g_row
    conv_row_sum u_row (
      .clk   (clk),
      .reset (reset),
      .en1_i (w_accept),
      .en2_i (v1_q),
      .pix_i (bus.i_window[win_idx(r, 0)*I_F_BW +: KX*I_F_BW]),
      .wgt_i (active_q[win_idx(r, 0) +: KX]),
      .sum_o (w_row_sum[r])
    );
  end

  // Final adder over the row sums, optionally clamped at zero.
  always_comb begin
    acc_d = '0;
    for (int r = 0; r < KY; r++) acc_d = acc_d + ACC_BW'(w_row_sum[r]);
`ifdef CONV_RELU_EN
    if (acc_d < 0) acc_d = '0;
`endif
  end

  // Valid pipeline and stage-3 result register (holds when idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      out_q <= '0;
    end else begin
      v1_q <= w_accept;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) out_q <= acc_d;
    end
  end

  assign bus.o_w_loaded  = loaded_q;
  assign bus.o_out_valid = v3_q;
  assign bus.o_out_data  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_conv5x5_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv5x5_engine
//  Description : Directed scoreboard bench for conv5x5_engine.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv5x5_engine;
  import conv5x5_engine_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv5x5_engine_if bus ();

  conv5x5_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     total  = 0;
  int     passed = 0;
  longint exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KK*I_F_BW-1:0] fill(input logic [I_F_BW-1:0] p);
    logic [KK*I_F_BW-1:0] w;
    for (int k = 0; k < KK; k++) w[k*I_F_BW +: I_F_BW] = p;
    return w;
  endfunction

  task automatic send_weight(input logic signed [W_BW-1:0] w);
    bus.i_w_valid = 1'b1;
    bus.i_w_data  = w;
    tick();
    bus.i_w_valid = 1'b0;
  endtask

  task automatic load_all(input logic signed [W_BW-1:0] w);
    for (int k = 0; k < KK; k++) send_weight(w);
  endtask

  task automatic send_window(input logic [KK*I_F_BW-1:0] win);
    bus.i_window_valid = 1'b1;
    bus.i_window       = win;
    tick();
    bus.i_window_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  initial begin
    longint exp_v;
    forever begin
      @(negedge clk);
      if (!reset && bus.o_out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got valid with data %0d, required no output",
                   longint'(bus.o_out_data));
        end else begin
          exp_v = exp_q.pop_front();
          check("out_data", longint'(bus.o_out_data), exp_v);
        end
      end
    end
  end

  initial begin
    logic [KK*I_F_BW-1:0] win;
    bus.i_window_valid = 1'b0;
    bus.i_window       = '0;
    bus.i_w_valid      = 1'b0;
    bus.i_w_data       = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset_w_loaded", bus.o_w_loaded, 0);
    check("reset_out_valid", bus.o_out_valid, 0);
    check("reset_out_data", bus.o_out_data, 0);

    // Windows before any kernel are dropped.
    repeat (3) send_window(fill(8'd10));
    // Partial load of 24 ones, with a gap.
    for (int k = 0; k < 12; k++) send_weight(8'sd1);
    repeat (2) tick();
    for (int k = 12; k < 24; k++) send_weight(8'sd1);
    send_window(fill(8'd10));
    repeat (4) tick();
    check("partial_w_loaded", bus.o_w_loaded, 0);
    check("partial_no_out", bus.o_out_valid, 0);
    send_weight(8'sd1);
    check("commit_w_loaded", bus.o_w_loaded, 1);

    // All ones x 10 = 250, exactly three cycles after acceptance.
    exp_q.push_back(250);
    send_window(fill(8'd10));
    check("lat_edge0", bus.o_out_valid, 0);
    tick();
    check("lat_edge1", bus.o_out_valid, 0);
    tick();
    check("lat_edge2", bus.o_out_valid, 1);
    tick();
    check("lat_pulse_end", bus.o_out_valid, 0);
    check("hold_data", bus.o_out_data, 250);
    drain();

    // Identity kernel: only the centre tap is 1; other pixels must not leak.
    for (int k = 0; k < KK; k++) send_weight((k == 12) ? 8'sd1 : 8'sd0);
    for (int i = 0; i < 10; i++) begin
      win = fill(8'd77);
      win[win_idx(2, 2)*I_F_BW +: I_F_BW] = 8'(i);
      exp_q.push_back(i);
      bus.i_window_valid = 1'b1;
      bus.i_window       = win;
      tick();
    end
    bus.i_window_valid = 1'b0;
    drain();

    // Extremes.
    load_all(-8'sd128);
`ifdef CONV_RELU_EN
    exp_q.push_back(0);
`else
    exp_q.push_back(-816000);
`endif
    send_window(fill(8'd255));
    drain();
    load_all(8'sd127);
    exp_q.push_back(809625);
    send_window(fill(8'd255));
    drain();

    // Reload all ones -> all twos under a continuous window stream.
    load_all(8'sd1);
    for (int t = 0; t < 30; t++) begin
      bus.i_window_valid = 1'b1;
      bus.i_window       = fill(8'd1);
      bus.i_w_valid      = (t < KK);
      bus.i_w_data       = 8'sd2;
      exp_q.push_back((t < KK) ? 25 : 50);
      tick();
    end
    bus.i_window_valid = 1'b0;
    bus.i_w_valid      = 1'b0;
    drain();

    // Reset one cycle after acceptance: the result is lost.
    send_window(fill(8'd10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_out_valid", bus.o_out_valid, 0);
    check("rst_out_data", bus.o_out_data, 0);
    check("rst_w_loaded", bus.o_w_loaded, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
